// File: rtl/stack_pkg.sv
// Shared definitions for the stack front end.
//
// Contents:
//   dbc_state_t              - debounce channel FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES  - stable cycles needed to accept a level change
//                              (10 ms at 100 MHz)
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } dbc_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchronizer, debounce FSM with stable-cycle
// counter, and a one-cycle raw pulse when a press is accepted.
//
// Ports:
//   Clk    - system clock
//   Reset  - synchronous, active-high reset
//   Btn    - raw asynchronous, bouncy button level
//   pulse  - combinational, high for the cycle in which the press is
//            accepted (the edge closing that cycle moves the FSM to HELD)
//
// The FSM state is held in the signal 'state' so it can be probed directly.
module debounce_channel
  import stack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn,
  output logic pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 s;
  dbc_state_t           state;
  dbc_state_t           state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync1 <= Btn;
      s     <= sync1;
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter is cleared on every state change, so in a wait state it
  // holds the number of stable cycles seen so far beyond the first.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pulse      = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          pulse      = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        // Release is debounced like a press but never emits a pulse.
        if (s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/push_pop_conditioner.sv
// Turns the raw PUSH/POP buttons into clean single-cycle strobes for the
// stack controller. Each button gets its own debounce channel; a small
// arbiter makes sure Push and Pop are never high in the same cycle.
//
// Ports:
//   Clk      - system clock (only clock)
//   Reset    - synchronous, active-high reset
//   PushBtn  - raw PUSH button, asynchronous and bouncy
//   PopBtn   - raw POP button, asynchronous and bouncy
//   Push     - registered one-cycle strobe per accepted PUSH press
//   Pop      - registered one-cycle strobe per accepted POP press
//
// Push and Pop are fire-and-forget strobes: there is no valid/ready
// handshake and no back-pressure; the consumer must act in the strobe cycle.
module push_pop_conditioner
  import stack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic PushBtn,
  input  logic PopBtn,
  output logic Push,
  output logic Pop
);

  logic push_pulse;
  logic pop_pulse;
  logic pop_pending;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_push_ch (
    .Clk  (Clk),
    .Reset(Reset),
    .Btn  (PushBtn),
    .pulse(push_pulse)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_pop_ch (
    .Clk  (Clk),
    .Reset(Reset),
    .Btn  (PopBtn),
    .pulse(pop_pulse)
  );

  // On a collision Push wins and Pop is deferred by exactly one cycle.
  // A fresh push or pop pulse cannot land on the deferred cycle because
  // each channel needs at least two stable cycles between pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Push        <= 1'b0;
      Pop         <= 1'b0;
      pop_pending <= 1'b0;
    end else begin
      Push        <= push_pulse;
      Pop         <= pop_pending | (pop_pulse & ~push_pulse);
      pop_pending <= push_pulse & pop_pulse;
    end
  end

endmodule

// File: tb/tb_push_pop_conditioner.sv
// Directed bench for push_pop_conditioner with DEBOUNCE_CYCLES = 4.
// Edge numbering: inputs for a scenario are driven just after "edge 0";
// after each later posedge e the outputs seen are those of the cycle after
// edge e.
module tb_push_pop_conditioner;
  import stack_pkg::*;

  localparam int DC = 4;

  logic Clk = 1'b0;
  logic Reset;
  logic PushBtn;
  logic PopBtn;
  logic Push;
  logic Pop;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  push_pop_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .PushBtn(PushBtn),
    .PopBtn (PopBtn),
    .Push   (Push),
    .Pop    (Pop)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_gap(input int n);
    PushBtn = 1'b0;
    PopBtn  = 1'b0;
    repeat (n) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset   = 1'b1;
    PushBtn = 1'b0;
    PopBtn  = 1'b0;
    repeat (3) tick();
    checks++;
    if (Push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", Push); end
    checks++;
    if (Pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", Pop); end
    checks++;
    if (dut.pop_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", dut.pop_pending); end
    checks++;
    if (dut.u_push_ch.state !== IDLE || dut.u_pop_ch.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got push=%0d pop=%0d want 0/0", dut.u_push_ch.state, dut.u_pop_ch.state);
    end
    checks++;
    if (dut.u_push_ch.cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dut.u_push_ch.cnt); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_clean_press();
    int n_push;
    n_push = 0;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e > 0) begin
        checks++;
        if (Push !== (e == 7)) begin errors++; $display("FAIL clean_push e=%0d: got %b want %b", e, Push, (e == 7)); end
        checks++;
        if (Pop !== 1'b0) begin errors++; $display("FAIL clean_pop e=%0d: got %b want 0", e, Pop); end
        if (Push === 1'b1) n_push++;
      end
      PushBtn = 1'b1;
    end
    checks++;
    if (n_push != 1) begin errors++; $display("FAIL clean_count: got %0d want 1", n_push); end
    checks++;
    if (dut.u_push_ch.state !== HELD) begin errors++; $display("FAIL clean_held: got %0d want %0d", dut.u_push_ch.state, HELD); end
    idle_gap(12);
    checks++;
    if (dut.u_push_ch.state !== IDLE) begin errors++; $display("FAIL clean_release: got %0d want %0d", dut.u_push_ch.state, IDLE); end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    int n_pop;
    pat   = 4'b0101; // driven after edges 0..3: 1,0,1,0
    n_pop = 0;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e > 0) begin
        checks++;
        if (Pop !== (e == 11)) begin errors++; $display("FAIL bounce_pop e=%0d: got %b want %b", e, Pop, (e == 11)); end
        checks++;
        if (Push !== 1'b0) begin errors++; $display("FAIL bounce_push e=%0d: got %b want 0", e, Push); end
        if (Pop === 1'b1) n_pop++;
      end
      PopBtn = (e < 4) ? pat[e] : 1'b1;
    end
    checks++;
    if (n_pop != 1) begin errors++; $display("FAIL bounce_count: got %0d want 1", n_pop); end
    idle_gap(12);
  endtask

  task automatic test_short_glitch();
    for (int e = 0; e <= 15; e++) begin
      tick();
      if (e > 0) begin
        checks++;
        if (Push !== 1'b0) begin errors++; $display("FAIL glitch_push e=%0d: got %b want 0", e, Push); end
      end
      if (e == 3) begin
        checks++;
        if (dut.u_push_ch.state !== PRESS_WAIT) begin errors++; $display("FAIL glitch_wait: got %0d want %0d", dut.u_push_ch.state, PRESS_WAIT); end
      end
      PushBtn = (e < 3);
    end
    checks++;
    if (dut.u_push_ch.state !== IDLE) begin errors++; $display("FAIL glitch_idle: got %0d want %0d", dut.u_push_ch.state, IDLE); end
  endtask

  task automatic test_simultaneous();
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e > 0) begin
        checks++;
        if (Push !== (e == 7)) begin errors++; $display("FAIL simul_push e=%0d: got %b want %b", e, Push, (e == 7)); end
        checks++;
        if (Pop !== (e == 8)) begin errors++; $display("FAIL simul_pop e=%0d: got %b want %b", e, Pop, (e == 8)); end
        checks++;
        if ((Push & Pop) !== 1'b0) begin errors++; $display("FAIL simul_overlap e=%0d: got push=%b pop=%b want not both", e, Push, Pop); end
      end
      if (e == 7) begin
        checks++;
        if (dut.pop_pending !== 1'b1) begin errors++; $display("FAIL simul_pending: got %b want 1", dut.pop_pending); end
      end
      PushBtn = 1'b1;
      PopBtn  = 1'b1;
    end
    idle_gap(12);
  endtask

  task automatic test_release_bounce();
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e > 0) begin
        checks++;
        if (Push !== (e == 7)) begin errors++; $display("FAIL relb_press e=%0d: got %b want %b", e, Push, (e == 7)); end
      end
      PushBtn = 1'b1;
    end
    for (int e = 0; e <= 15; e++) begin
      tick();
      if (e > 0) begin
        checks++;
        if (Push !== 1'b0) begin errors++; $display("FAIL relb_push e=%0d: got %b want 0", e, Push); end
      end
      if (e == 3) begin
        checks++;
        if (dut.u_push_ch.state !== RELEASE_WAIT) begin errors++; $display("FAIL relb_wait: got %0d want %0d", dut.u_push_ch.state, RELEASE_WAIT); end
      end
      PushBtn = !(e == 0 || e == 1);
    end
    checks++;
    if (dut.u_push_ch.state !== HELD) begin errors++; $display("FAIL relb_held: got %0d want %0d", dut.u_push_ch.state, HELD); end
    idle_gap(12);
  endtask

  task automatic test_reset_mid();
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e > 0) begin
        checks++;
        if (Push !== (e == 13)) begin errors++; $display("FAIL rstmid_push e=%0d: got %b want %b", e, Push, (e == 13)); end
        checks++;
        if (Pop !== 1'b0) begin errors++; $display("FAIL rstmid_pop e=%0d: got %b want 0", e, Pop); end
      end
      if (e == 6) begin
        checks++;
        if (dut.u_push_ch.state !== IDLE || dut.u_push_ch.cnt !== 2'd0) begin
          errors++;
          $display("FAIL rstmid_abort: got state=%0d cnt=%0d want 0/0", dut.u_push_ch.state, dut.u_push_ch.cnt);
        end
      end
      PushBtn = 1'b1;
      Reset   = (e == 4 || e == 5);
    end
    idle_gap(12);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    Reset   = 1'b1;
    PushBtn = 1'b0;
    PopBtn  = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_glitch();
    test_simultaneous();
    test_release_bounce();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
